// File: rtl/matrix_spi_pkg.sv
// Shared definitions for the LED-matrix SPI back-end:
// register map, init-sequence table, FSM states and row-frame packing.
package matrix_spi_pkg;

    localparam logic [3:0] REG_NOOP    = 4'h0;
    localparam logic [3:0] REG_DIGIT0  = 4'h1;
    localparam logic [3:0] REG_DECODE  = 4'h9;
    localparam logic [3:0] REG_INTENS  = 4'hA;
    localparam logic [3:0] REG_SCANLIM = 4'hB;
    localparam logic [3:0] REG_SHUTDN  = 4'hC;
    localparam logic [3:0] REG_TEST    = 4'hF;

    localparam int INIT_LEN = 5;

    typedef enum logic [2:0] {
        ST_INIT,
        ST_IDLE,
        ST_LOAD,
        ST_SEND,
        ST_DONE
    } state_t;

    function automatic logic [15:0] init_word(
        input logic [2:0] idx,
        input logic [3:0] intensity
    );
        logic [15:0] w;
        case (idx)
            3'd0:    w = {4'h0, REG_SHUTDN, 8'h01};
            3'd1:    w = {4'h0, REG_DECODE, 8'h00};
            3'd2:    w = {4'h0, REG_SCANLIM, 8'h07};
            3'd3:    w = {4'h0, REG_INTENS, 4'h0, intensity};
            3'd4:    w = {4'h0, REG_TEST, 8'h00};
            default: w = {4'h0, REG_NOOP, 8'h00};
        endcase
        return w;
    endfunction

    // Digit register r+1 carries height r; bit c of the data byte is column c.
    function automatic logic [15:0] row_frame(
        input logic [63:0] m,
        input logic [2:0]  r
    );
        logic [7:0] b;
        for (int c = 0; c < 8; c++) begin
            b[c] = m[c*8 + int'(r)];
        end
        return {4'h0, REG_DIGIT0 + {1'b0, r}, b};
    endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// Serialises one 16-bit word MSB first: CDIV-cycle low/high sclk phases,
// then a CDIV hold with cs low and a CDIV gap with cs high.
module spi_frame_tx #(
    parameter int CDIV = 4
) (
    input  logic        clk_i,
    input  logic        reset_ni,
    input  logic        start_i,
    input  logic [15:0] word_i,
    output logic        ready_o,
    output logic        cs_no,
    output logic        sclk_o,
    output logic        mosi_o
);

    localparam int DW = (CDIV > 1) ? $clog2(CDIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CDIV - 1);

    localparam logic [1:0] TX_IDLE = 2'd0;
    localparam logic [1:0] TX_BITS = 2'd1;
    localparam logic [1:0] TX_HOLD = 2'd2;
    localparam logic [1:0] TX_GAP  = 2'd3;

    logic [1:0]    r_stage;
    logic [DW-1:0] r_div;
    logic [3:0]    r_bit;
    logic [15:0]   r_word;
    logic          r_cs_n;
    logic          r_sclk;
    logic          r_mosi;
    logic          w_div_end;
    logic          w_accept;

    assign w_div_end = (r_div == DIV_LAST);
    // Ready on the last gap cycle lets the parent chain frames with no bubble.
    assign ready_o   = (r_stage == TX_IDLE) ||
                       ((r_stage == TX_GAP) && w_div_end);
    assign w_accept  = start_i && ready_o;

    assign cs_no  = r_cs_n;
    assign sclk_o = r_sclk;
    assign mosi_o = r_mosi;

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_stage <= TX_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_word  <= '0;
            r_cs_n  <= 1'b1;
            r_sclk  <= 1'b0;
            r_mosi  <= 1'b0;
        end else if (w_accept) begin
            r_stage <= TX_BITS;
            r_div   <= '0;
            r_bit   <= 4'd15;
            r_word  <= word_i;
            r_cs_n  <= 1'b0;
            r_sclk  <= 1'b0;
            r_mosi  <= word_i[15];
        end else begin
            if (r_stage != TX_IDLE) begin
                r_div <= w_div_end ? '0 : r_div + DW'(1);
            end
            case (r_stage)
                TX_BITS: begin
                    if (w_div_end) begin
                        if (!r_sclk) begin
                            r_sclk <= 1'b1;
                        end else if (r_bit == 4'd0) begin
                            r_sclk  <= 1'b0;
                            r_stage <= TX_HOLD;
                        end else begin
                            r_sclk <= 1'b0;
                            r_bit  <= r_bit - 4'd1;
                            r_mosi <= r_word[r_bit - 4'd1];
                        end
                    end
                end
                TX_HOLD: begin
                    if (w_div_end) begin
                        r_cs_n  <= 1'b1;
                        r_stage <= TX_GAP;
                    end
                end
                TX_GAP: begin
                    if (w_div_end) begin
                        r_stage <= TX_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/matrix_spi_driver.sv
// LED-matrix display back-end: init sequence, frame snapshot and
// eight row frames per refresh over SPI, with busy/done pacing.
module matrix_spi_driver
    import matrix_spi_pkg::*;
#(
    parameter int         gs        = 8,
    parameter int         CDIV      = 4,
    parameter logic [3:0] INTENSITY = 4'h8
) (
    input  logic             clk_i,
    input  logic             reset_ni,
    input  logic [gs*gs-1:0] matrix_i,
    input  logic             update_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             cs_no,
    output logic             sclk_o,
    output logic             mosi_o
);

    state_t           r_state;
    logic [gs*gs-1:0] r_snap;
    logic [2:0]       r_row;
    logic [2:0]       r_init;
    logic             r_pend;
    logic             w_start;
    logic             w_ready;
    logic [15:0]      w_word;

    spi_frame_tx #(
        .CDIV(CDIV)
    ) u_tx (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .start_i (w_start),
        .word_i  (w_word),
        .ready_o (w_ready),
        .cs_no   (cs_no),
        .sclk_o  (sclk_o),
        .mosi_o  (mosi_o)
    );

    assign busy_o = (r_state != ST_IDLE) && (r_state != ST_DONE);
    assign done_o = (r_state == ST_DONE);

    // Row 0 leaves during LOAD, so it is packed from matrix_i directly.
    always_comb begin
        w_start = 1'b0;
        w_word  = '0;
        unique case (r_state)
            ST_INIT: begin
                if (w_ready && (r_init != 3'(INIT_LEN))) begin
                    w_start = 1'b1;
                    w_word  = init_word(r_init, INTENSITY);
                end
            end
            ST_LOAD: begin
                w_start = 1'b1;
                w_word  = row_frame(matrix_i, 3'd0);
            end
            ST_SEND: begin
                if (w_ready && (r_row != 3'd7)) begin
                    w_start = 1'b1;
                    w_word  = row_frame(r_snap, r_row + 3'd1);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            r_state <= ST_INIT;
            r_snap  <= '0;
            r_row   <= '0;
            r_init  <= '0;
            r_pend  <= 1'b0;
        end else begin
            unique case (r_state)
                ST_INIT: begin
                    r_pend <= r_pend | update_i;
                    if (w_ready) begin
                        if (r_init == 3'(INIT_LEN)) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_init <= r_init + 3'd1;
                        end
                    end
                end
                ST_IDLE: begin
                    if (update_i || r_pend) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_snap  <= matrix_i;
                    r_pend  <= update_i;
                    r_row   <= '0;
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    r_pend <= r_pend | update_i;
                    if (w_ready) begin
                        if (r_row == 3'd7) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_row <= r_row + 3'd1;
                        end
                    end
                end
                ST_DONE: begin
                    r_pend  <= r_pend | update_i;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_INIT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_spi_driver.sv
// Bench for matrix_spi_driver: timeline model checked every cycle plus
// decoded-frame and timing checks at CDIV=4 and CDIV=1.
module tb_matrix_spi_driver;

    localparam int C = 4;
    localparam int F = 34 * C;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, upd;
    logic [63:0] mat;
    logic        busy, done, cs_n, sclk, mosi;
    logic        rst1_n, upd1;
    logic [63:0] mat1;
    logic        busy1, done1, cs1_n, sclk1, mosi1;

    matrix_spi_driver #(.gs(8), .CDIV(C), .INTENSITY(4'h8)) u_dut (
        .clk_i(clk), .reset_ni(rst_n), .matrix_i(mat), .update_i(upd),
        .busy_o(busy), .done_o(done), .cs_no(cs_n), .sclk_o(sclk),
        .mosi_o(mosi)
    );

    matrix_spi_driver #(.gs(8), .CDIV(1), .INTENSITY(4'h8)) u_dut1 (
        .clk_i(clk), .reset_ni(rst1_n), .matrix_i(mat1), .update_i(upd1),
        .busy_o(busy1), .done_o(done1), .cs_no(cs1_n), .sclk_o(sclk1),
        .mosi_o(mosi1)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int gcyc    = 0;

    logic [15:0] init_exp [5] = '{16'h0C01, 16'h0900, 16'h0B07, 16'h0A08, 16'h0F00};
    logic [15:0] diag_exp [8] = '{16'h0101, 16'h0202, 16'h0304, 16'h0408,
                                  16'h0510, 16'h0620, 16'h0740, 16'h0880};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) gcyc++;

    // Frame decoders: shift MOSI on SCLK rise, keep only complete 16-bit frames.
    logic [15:0] sh = '0, sh1 = '0;
    int nb = 0, nb1 = 0;
    logic [15:0] frames[$];
    logic [15:0] frames1[$];
    always @(posedge sclk) begin sh = {sh[14:0], mosi}; nb++; end
    always @(negedge cs_n) nb = 0;
    always @(posedge cs_n) begin if (nb == 16) frames.push_back(sh); nb = 0; end
    always @(posedge sclk1) begin sh1 = {sh1[14:0], mosi1}; nb1++; end
    always @(negedge cs1_n) nb1 = 0;
    always @(posedge cs1_n) begin if (nb1 == 16) frames1.push_back(sh1); nb1 = 0; end

    int lowcnt = 0;
    int lows[$];
    int falls[$];
    int dones[$];
    logic p_cs = 1'b1;
    always @(negedge clk) begin
        if (cs_n === 1'b0) lowcnt++;
        else if (lowcnt != 0) begin lows.push_back(lowcnt); lowcnt = 0; end
        if (cs_n === 1'b0 && p_cs !== 1'b0) falls.push_back(gcyc);
        if (done === 1'b1) dones.push_back(gcyc);
        p_cs = cs_n;
    end

    int lowcnt1 = 0, tog1 = 0, viol1 = 0;
    int lows1[$];
    int togs1[$];
    int falls1[$];
    logic p_cs1 = 1'b1, p_sclk1 = 1'b0, p_mosi1 = 1'b0;
    always @(negedge clk) begin
        if (cs1_n === 1'b0) begin
            lowcnt1++;
            if (p_cs1 === 1'b0) begin
                if (sclk1 !== p_sclk1) tog1++;
                if (mosi1 !== p_mosi1 && !(sclk1 === 1'b0 && p_sclk1 === 1'b1)) viol1++;
            end else begin
                falls1.push_back(gcyc);
            end
        end else if (lowcnt1 != 0) begin
            lows1.push_back(lowcnt1);
            togs1.push_back(tog1);
            lowcnt1 = 0;
            tog1 = 0;
        end
        p_cs1 = cs1_n; p_sclk1 = sclk1; p_mosi1 = mosi1;
    end

    // Timeline model: a burst of m_n frames whose first cs fall is cycle m_t0.
    int m_cyc = 0, m_t0 = 1, m_n = 5;
    bit m_ref = 0, m_pend = 0, m_live = 0;
    logic [15:0] m_words [8];
    always @(negedge clk) begin
        logic [4:0] e, act, msk;
        int off, t, f;
        logic [7:0] b;
        if (m_live) begin
            act = {busy, done, cs_n, sclk, mosi};
            msk = 5'b11110;
            if (m_cyc == m_t0 - 1) begin
                e = 5'b10100;
                if (!m_ref) msk = 5'b11111;
            end else if (m_cyc >= m_t0 && m_cyc < m_t0 + m_n * F) begin
                off = m_cyc - m_t0;
                f = off / F;
                t = off % F;
                e[4] = 1'b1;
                e[3] = 1'b0;
                e[2] = (t >= 33 * C);
                e[1] = (t < 32 * C) ? (((t / C) % 2) == 1) : 1'b0;
                e[0] = 1'b0;
                if (t < 32 * C) begin
                    e[0] = m_words[f][15 - t / (2 * C)];
                    msk = 5'b11111;
                end
            end else if (m_ref && m_cyc == m_t0 + m_n * F) begin
                e = 5'b01100;
            end else begin
                e = 5'b00100;
            end
            chk($sformatf("pins@%0d", m_cyc), 32'(act & msk), 32'(e & msk));
        end
        if (rst_n !== 1'b1) begin
            m_live = 1; m_cyc = 0; m_t0 = 1; m_n = 5; m_ref = 0; m_pend = 0;
            for (int i = 0; i < 5; i++) m_words[i] = init_exp[i];
        end else if (m_live) begin
            if (m_cyc == m_t0 - 1) begin
                if (m_ref) begin
                    for (int r = 0; r < 8; r++) begin
                        for (int c = 0; c < 8; c++) b[c] = mat[c * 8 + r];
                        m_words[r] = {4'h0, 4'(r + 1), b};
                    end
                    m_pend = upd;
                end else begin
                    m_pend = m_pend | upd;
                end
            end else if ((m_cyc >= m_t0 && m_cyc < m_t0 + m_n * F) ||
                         (m_ref && m_cyc == m_t0 + m_n * F)) begin
                m_pend = m_pend | upd;
            end else if (upd || m_pend) begin
                m_t0 = m_cyc + 2; m_n = 8; m_ref = 1; m_pend = 0;
            end
            m_cyc++;
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_upd();
        upd = 1'b1; tick(); upd = 1'b0;
    endtask

    task automatic clear_q();
        frames.delete(); lows.delete(); falls.delete(); dones.delete();
    endtask

    task automatic wait_idle(input int bound, input string name);
        for (int i = 0; i < bound; i++) begin
            if (busy === 1'b0) break;
            tick();
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic wait_done(input int target, input int bound, input string name);
        for (int i = 0; i < bound; i++) begin
            if (dones.size() >= target) break;
            tick();
        end
        chk(name, 32'(dones.size()), 32'(target));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_rel, t_i;
        rst_n = 0; rst1_n = 0; upd = 0; upd1 = 0; mat = '0; mat1 = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_pins", 32'({busy, done, cs_n, sclk, mosi}), 32'(5'b10100));
        clear_q();
        rst_n = 1;
        t_rel = gcyc;
        wait_idle(1000, "init_timeout");
        chk("init_cs_fall", 32'(falls[0] - t_rel), 32'd1);
        chk("init_busy_fall", 32'(gcyc - falls[0]), 32'd680);
        chk("init_nframes", 32'(frames.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("init_frame%0d", i), 32'(frames[i]), 32'(init_exp[i]));
        for (int i = 0; i < 5; i++) chk($sformatf("init_cs_low%0d", i), 32'(lows[i]), 32'd132);
        chk("init_no_done", 32'(dones.size()), 32'd0);

        repeat (5) tick();
        clear_q();
        mat = 64'h8040201008040201;
        t_i = gcyc;
        pulse_upd();
        wait_done(1, 1500, "diag_done");
        chk("diag_cs_fall", 32'(falls[0] - t_i), 32'd2);
        chk("diag_done_lat", 32'(dones[0] - falls[0]), 32'd1088);
        chk("diag_done_width", 32'(done), 32'd0);
        chk("diag_nframes", 32'(frames.size()), 32'd8);
        for (int i = 0; i < 8; i++) chk($sformatf("diag_frame%0d", i), 32'(frames[i]), 32'(diag_exp[i]));

        repeat (5) tick();
        clear_q();
        mat = 64'h00000000000000FF;
        pulse_upd();
        repeat (300) tick();
        pulse_upd();
        repeat (100) tick();
        mat = '1;
        repeat (200) tick();
        pulse_upd();
        wait_done(2, 3000, "pend_done2");
        repeat (300) tick();
        chk("pend_ndone", 32'(dones.size()), 32'd2);
        chk("pend_nframes", 32'(frames.size()), 32'd16);
        for (int r = 0; r < 8; r++) chk($sformatf("pend_old%0d", r), 32'(frames[r]), 32'({8'(r + 1), 8'h01}));
        for (int r = 0; r < 8; r++) chk($sformatf("pend_new%0d", r), 32'(frames[8 + r]), 32'({8'(r + 1), 8'hFF}));
        chk("pend_restart", 32'(falls[8] - dones[0]), 32'd3);

        clear_q();
        mat = 64'h00FF00FF00FF00FF;
        pulse_upd();
        for (int i = 0; i < 10 && falls.size() == 0; i++) tick();
        repeat (65) tick();
        rst_n = 0;
        tick();
        rst_n = 1;
        chk("midrst_cs", 32'(cs_n), 32'd1);
        chk("midrst_sclk", 32'(sclk), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd1);
        wait_idle(1000, "midrst_init_timeout");
        chk("midrst_nframes", 32'(frames.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("midrst_frame%0d", i), 32'(frames[i]), 32'(init_exp[i]));
        chk("midrst_no_done", 32'(dones.size()), 32'd0);

        frames1.delete(); lows1.delete(); togs1.delete(); falls1.delete();
        viol1 = 0;
        rst1_n = 1;
        t_rel = gcyc;
        for (int i = 0; i < 400; i++) begin
            if (busy1 === 1'b0) break;
            tick();
        end
        chk("c1_idle", 32'(busy1), 32'd0);
        chk("c1_cs_fall", 32'(falls1[0] - t_rel), 32'd1);
        chk("c1_busy_fall", 32'(gcyc - falls1[0]), 32'd170);
        chk("c1_nframes", 32'(frames1.size()), 32'd5);
        for (int i = 0; i < 5; i++) chk($sformatf("c1_frame%0d", i), 32'(frames1[i]), 32'(init_exp[i]));
        for (int i = 0; i < 5; i++) chk($sformatf("c1_cs_low%0d", i), 32'(lows1[i]), 32'd33);
        for (int i = 0; i < 5; i++) chk($sformatf("c1_toggles%0d", i), 32'(togs1[i]), 32'd32);
        for (int i = 0; i < 4; i++) chk($sformatf("c1_period%0d", i), 32'(falls1[i + 1] - falls1[i]), 32'd34);
        chk("c1_mosi_stable", 32'(viol1), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/matrix_spi_driver.md
# matrix_spi_driver

Display back-end stage that consumes the 64-bit frame matrix produced by the game/action stage and writes it to an external MAX7219-style 8×8 LED driver over a 3-wire SPI link. After reset it runs a fixed initialisation sequence. It then snapshots the matrix on each update request and serialises eight 16-bit row frames. It provides a busy/done handshake so the producer or top level can pace refreshes.

## Interface
- `gs`, 8: grid size; only 8 is supported (register map is 8 digits).
- `CDIV`, 4: SPI half-period in `clk_i` cycles; legal range 1..255.
- `INTENSITY`, 4'h8: value written to the intensity register during init.

- `clk_i`  in  1  system clock; all logic on rising edge.
- `reset_ni`  in  1  reset, synchronous, active-low.
- `matrix_i`  in  gs*gs  frame; bit `c*gs + h` = column `c`, height `h`.
- `update_i`  in  1  refresh request, sampled every cycle.
- `busy_o`  out  1  high during init or a refresh.
- `done_o`  out  1  one-cycle pulse when a refresh completes.
- `cs_no`  out  1  SPI chip select, active-low.
- `sclk_o`  out  1  SPI clock, idle low.
- `mosi_o`  out  1  SPI data, MSB first.

## Operation
- Reset (`reset_ni`=0 at a clock edge):
  - Outputs go to `cs_no`=1, `sclk_o`=0, `mosi_o`=0, `busy_o`=1, `done_o`=0.
  - The pending flag clears and the FSM goes to INIT.
  - A reset in the middle of a frame aborts it immediately. The partial frame is discarded because CS rises without a valid latch edge.
- FSM states are INIT, IDLE, LOAD, SEND, DONE.
- INIT sends 5 frames in this order: 0x0C01 (normal operation), 0x0900 (no decode), 0x0B07 (scan all 8), `0x0A0` concatenated with `INTENSITY`, 0x0F00 (test off).
  - INIT then goes to IDLE. No `done_o` pulse follows init.
- IDLE: `busy_o`=0. When `update_i`=1 or the pending flag is set, go to LOAD.
- LOAD (1 cycle):
  - Snapshot `matrix_i` into an internal register and clear the pending flag.
  - Set `busy_o`=1 and row index r=0.
- SEND: transmit frame {4'h0, (r+1)[3:0], rowbyte(r)}, where rowbyte(r) bit c = snapshot[c*gs + r].
  - Frames go out for r = 0..7, i.e. address 1 carries height 0.
  - After the frame with r=7, go to DONE.
- DONE (1 cycle): `done_o`=1 and `busy_o`=0, then go to IDLE.
- `update_i` while busy sets the pending flag (one level deep; further requests merge). The pending request is serviced directly after DONE.
- `update_i` asserted in DONE is treated as pending.
- `matrix_i` changes during a refresh have no effect on the frames in flight.

## Timing
- Each frame takes exactly 34·CDIV cycles, measured from the cycle `cs_no` falls:
  - `cs_no` falls and `mosi_o` is set to bit 15 in the same cycle.
  - For each bit k from 15 down to 0: `sclk_o` is low for CDIV cycles, then high for CDIV cycles. The peripheral samples on the rising edge.
  - `mosi_o` changes only on the cycle `sclk_o` goes low.
  - After the last high phase, `sclk_o`=0 and `cs_no` stays low for CDIV cycles (hold).
  - `cs_no` then rises (the device latches on this edge) and stays high for CDIV cycles (gap).
- Back-to-back frames: the next `cs_no` fall comes on the cycle after the gap ends.
- Init takes 5·34·CDIV cycles from reset release; 680 cycles at CDIV=4.
- Refresh latency:
  - `update_i` sampled in IDLE, then LOAD on the next cycle.
  - The first `cs_no` fall is on the cycle after LOAD.
  - `done_o` comes 8·34·CDIV cycles after the first `cs_no` fall; 1088 cycles at CDIV=4.
- The divide counter is ceil(log2(CDIV)) bits wide, minimum 1. The bit counter is 4 bits and the row counter is 3 bits. All counters wrap only under FSM control.

## Structure
- Shared package `matrix_spi_pkg` holds:
  - register address constants (NOOP=0, DIGIT0=1, DECODE=9, INTENS=0xA, SCANLIM=0xB, SHUTDN=0xC, TEST=0xF);
  - the init-sequence table;
  - the FSM state enum.
- Sub-module `spi_frame_tx` serialises one 16-bit word.
  - Handshake: `start_i`/`word_i` in; `ready_o` high when idle. It owns `cs_no`, `sclk_o`, `mosi_o` and the CDIV divider.
  - It accepts `start_i` only when `ready_o`=1.
  - `ready_o` returns high on the last gap cycle, so the parent can restart with no bubble.
- The top module holds the FSM, snapshot register, row/init counters and pending flag.

## Test plan
- Reset release with CDIV=4: decode MOSI on `sclk_o` rising edges. Expect exactly 5 frames 0x0C01, 0x0900, 0x0B07, 0x0A08, 0x0F00, each `cs_no`-low window = 32·4+4 cycles, and `busy_o` falling 680 cycles after release.
- Diagonal matrix (bit i*8+i set) with a one-cycle `update_i` in IDLE: expect frames 0x0101, 0x0202, 0x0304, …, 0x0880, then `done_o` high for 1 cycle 1088 cycles after the first `cs_no` fall.
- Pulse `update_i` twice during a refresh and change `matrix_i` to all-ones mid-refresh: current frames still carry the old snapshot. Expect exactly one extra refresh of eight 0x0rFF frames and exactly two `done_o` pulses in total.
- Drive `reset_ni`=0 for 1 cycle in the middle of frame bit 7 of a refresh: expect `cs_no`=1, `sclk_o`=0, `busy_o`=1 on the next cycle, followed by the full 5-frame init sequence.
- CDIV=1: expect each frame to be exactly 34 cycles, `sclk_o` toggling every cycle, and MOSI stable across every rising edge.
